// File: rtl/nes_cpu_bus_responder_if.sv
// CPU-side bus of the NES memory responder: request/address/data from the
// 6502 core, read data and the one-cycle rdy completion pulse back to it.
interface nes_cpu_bus_responder_if;
  logic        cpu_req;
  logic [15:0] address;
  logic        readNotWrite;
  logic [7:0]  data_Out;
  logic [7:0]  data_In;
  logic        rdy;

  // CPU core side
  modport master (
    output cpu_req, address, readNotWrite, data_Out,
    input  data_In, rdy
  );

  // Responder side
  modport slave (
    input  cpu_req, address, readNotWrite, data_Out,
    output data_In, rdy
  );
endinterface

// File: rtl/nes_cpu_bus_responder.sv
// NES CPU bus responder: decodes each 6502 bus cycle into internal RAM,
// controller ports, open-bus APU/IO stubs, or an external PPU/cartridge
// request with an ack timeout, and paces the CPU with a one-cycle rdy.
module nes_cpu_bus_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      phi0,
  input  logic                      res,
  nes_cpu_bus_responder_if.slave    cpu,
  input  logic [7:0]                pad1_buttons,
  input  logic [7:0]                pad2_buttons,
  output logic                      ext_req,
  output logic                      ext_space,
  output logic [15:0]               ext_addr,
  output logic                      ext_rnw,
  output logic [7:0]                ext_wdata,
  input  logic                      ext_ack,
  input  logic [7:0]                ext_rdata,
  output logic                      bus_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, EXT_WAIT, RESP} state_t;
  typedef enum logic [2:0] {
    REG_RAM, REG_PPU, REG_CART, REG_STROBE, REG_PAD, REG_OTHER
  } region_t;

  state_t           state;
  region_t          region;
  logic [7:0]       ram [2048];
  logic [7:0]       open_bus;
  logic             strobe;
  logic [7:0]       shift1;
  logic [7:0]       shift2;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_next;
  logic             acc_rnw;
  logic [7:0]       acc_wdata;
  logic             pad_bit;
  logic             accept;

  assign accept    = (state == IDLE) && cpu.cpu_req;
  assign wait_next = wait_cnt + CNT_W'(1);

  // Address decode of the current CPU cycle into a map region
  // NOTE: region gets a default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    region = REG_OTHER;
    if (cpu.address[15:13] == 3'b000)
      region = REG_RAM;
    else if (cpu.address[15:13] == 3'b001)
      region = REG_PPU;
    else if (cpu.address[15:5] != 11'h200)
      region = REG_CART;
    else if (cpu.address == 16'h4016 && !cpu.readNotWrite)
      region = REG_STROBE;
    else if ((cpu.address == 16'h4016 || cpu.address == 16'h4017) && cpu.readNotWrite)
      region = REG_PAD;
  end

  // Controller data bit: live A button while strobed, else shifter LSB
  always_comb begin
    if (cpu.address[0])
      pad_bit = strobe ? pad2_buttons[0] : shift2[0];
    else
      pad_bit = strobe ? pad1_buttons[0] : shift1[0];
  end

  // Internal 2 KiB RAM write port, mirrored over $0000-$1FFF
  // NOTE: the array has no reset on purpose; contents are undefined until
  // written, which lets it map onto a plain block RAM.
  always_ff @(posedge phi0) begin
    if (!res && accept && region == REG_RAM && !cpu.readNotWrite)
      ram[cpu.address[10:0]] <= cpu.data_Out;
  end

  // Bus FSM with registered outputs, controller shifters and open bus
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge phi0) begin
    if (res) begin
      state       <= IDLE;
      cpu.rdy     <= 1'b0;
      cpu.data_In <= 8'h00;
      ext_req     <= 1'b0;
      ext_space   <= 1'b0;
      ext_addr    <= 16'h0000;
      ext_rnw     <= 1'b1;
      ext_wdata   <= 8'h00;
      bus_timeout <= 1'b0;
      strobe      <= 1'b0;
      shift1      <= 8'h00;
      shift2      <= 8'h00;
      open_bus    <= 8'h00;
      wait_cnt    <= '0;
      acc_rnw     <= 1'b1;
      acc_wdata   <= 8'h00;
    end else begin
      cpu.rdy <= 1'b0;
      if (strobe) begin
        shift1 <= pad1_buttons;
        shift2 <= pad2_buttons;
      end

      case (state)
        IDLE: begin
          if (cpu.cpu_req) begin
            acc_rnw   <= cpu.readNotWrite;
            acc_wdata <= cpu.data_Out;
            case (region)
              REG_RAM: begin
                if (cpu.readNotWrite)
                  cpu.data_In <= ram[cpu.address[10:0]];
                cpu.rdy <= 1'b1;
                state   <= RESP;
              end
              REG_PPU, REG_CART: begin
                ext_req   <= 1'b1;
                ext_space <= (region == REG_CART);
                ext_addr  <= (region == REG_CART) ? cpu.address
                                                  : (16'h2000 | {13'd0, cpu.address[2:0]});
                ext_rnw   <= cpu.readNotWrite;
                ext_wdata <= cpu.data_Out;
                wait_cnt  <= '0;
                state     <= EXT_WAIT;
              end
              REG_STROBE: begin
                strobe  <= cpu.data_Out[0];
                cpu.rdy <= 1'b1;
                state   <= RESP;
              end
              REG_PAD: begin
                cpu.data_In <= {open_bus[7:5], 4'b0000, pad_bit};
                if (!strobe) begin
                  if (cpu.address[0])
                    shift2 <= {1'b1, shift2[7:1]};
                  else
                    shift1 <= {1'b1, shift1[7:1]};
                end
                cpu.rdy <= 1'b1;
                state   <= RESP;
              end
              default: begin
                if (cpu.readNotWrite)
                  cpu.data_In <= open_bus;
                cpu.rdy <= 1'b1;
                state   <= RESP;
              end
            endcase
          end
        end

        EXT_WAIT: begin
          if (ext_ack) begin
            if (ext_rnw)
              cpu.data_In <= ext_rdata;
            ext_req  <= 1'b0;
            wait_cnt <= '0;
            cpu.rdy  <= 1'b1;
            state    <= RESP;
          end else if (wait_next == WAIT_LIMIT) begin
            if (ext_rnw)
              cpu.data_In <= open_bus;
            bus_timeout <= 1'b1;
            ext_req     <= 1'b0;
            wait_cnt    <= '0;
            cpu.rdy     <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_next;
          end
        end

        RESP: begin
          open_bus <= acc_rnw ? cpu.data_In : acc_wdata;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// Self-checking bench for nes_cpu_bus_responder: directed scenarios from the
// NES map rules plus a randomized mix checked against a behavioural model.
module tb_nes_cpu_bus_responder;
  localparam int TIMEOUT = 4;

  logic        phi0 = 1'b0;
  logic        res  = 1'b1;
  logic [7:0]  pad1_buttons = 8'h00;
  logic [7:0]  pad2_buttons = 8'h00;
  logic        ext_req, ext_space, ext_rnw, bus_timeout;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack   = 1'b0;
  logic [7:0]  ext_rdata = 8'h00;

  int checks = 0;
  int errors = 0;

  nes_cpu_bus_responder_if cpu_bus ();

  nes_cpu_bus_responder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .phi0         (phi0),
    .res          (res),
    .cpu          (cpu_bus),
    .pad1_buttons (pad1_buttons),
    .pad2_buttons (pad2_buttons),
    .ext_req      (ext_req),
    .ext_space    (ext_space),
    .ext_addr     (ext_addr),
    .ext_rnw      (ext_rnw),
    .ext_wdata    (ext_wdata),
    .ext_ack      (ext_ack),
    .ext_rdata    (ext_rdata),
    .bus_timeout  (bus_timeout)
  );

  always #5 phi0 = ~phi0;

  // ---------------- behavioural model of the NES bus map ----------------
  logic [7:0] m_ram [2048];
  bit         m_valid [2048];
  logic [7:0] m_ob;
  bit         m_strobe;
  logic [7:0] m_lat1, m_lat2;
  int         m_idx1, m_idx2;

  function automatic void model_reset();
    m_ob = 8'h00; m_strobe = 0; m_lat1 = 8'h00; m_lat2 = 8'h00;
    m_idx1 = 0; m_idx2 = 0;
  endfunction

  // ack_at <= 0 means no ack is given (timeout path)
  function automatic void model_access(input logic [15:0] a, input bit rnw,
                                       input logic [7:0] wd, input int ack_at,
                                       input logic [7:0] rd, output logic [7:0] exp_d,
                                       output int exp_lat, output bit exp_valid);
    logic [7:0] pads;
    int idx;
    bit b;
    exp_d = 8'h00; exp_lat = 1; exp_valid = rnw;
    if (a < 16'h2000) begin
      if (rnw) exp_d = m_ram[a % 2048];
      else begin m_ram[a % 2048] = wd; m_valid[a % 2048] = 1; end
    end else if (a < 16'h4000 || a >= 16'h4020) begin
      exp_lat = (ack_at > 0) ? ack_at + 1 : TIMEOUT + 1;
      exp_d   = (ack_at > 0) ? rd : m_ob;
    end else if (a == 16'h4016 && !rnw) begin
      if (m_strobe && !wd[0]) begin
        m_lat1 = pad1_buttons; m_lat2 = pad2_buttons; m_idx1 = 0; m_idx2 = 0;
      end
      m_strobe = wd[0];
    end else if ((a == 16'h4016 || a == 16'h4017) && rnw) begin
      pads = a[0] ? pad2_buttons : pad1_buttons;
      if (m_strobe) b = pads[0];
      else begin
        pads = a[0] ? m_lat2 : m_lat1;
        idx  = a[0] ? m_idx2 : m_idx1;
        b    = (idx < 8) ? pads[idx] : 1'b1;
        if (a[0]) m_idx2++; else m_idx1++;
      end
      exp_d = {m_ob[7:5], 4'b0000, b};
    end else begin
      exp_d = m_ob;
    end
    m_ob = rnw ? exp_d : wd;
  endfunction

  // ---------------- one CPU bus cycle, sampled 1 ns after each edge ----------------
  task automatic access(input logic [15:0] a, input bit rnw, input logic [7:0] wd,
                        input int ack_at, input logic [7:0] rd,
                        output logic [7:0] dout, output int lat, output int req_cycles,
                        output logic sp, output logic [15:0] ea, output logic ernw,
                        output logic [7:0] ewd, output logic rdy_after);
    lat = -1; req_cycles = 0; dout = 8'h00;
    sp = 1'bx; ea = 16'hxxxx; ernw = 1'bx; ewd = 8'hxx;
    cpu_bus.cpu_req = 1'b1; cpu_bus.address = a;
    cpu_bus.readNotWrite = rnw; cpu_bus.data_Out = wd;
    ext_rdata = rd;
    @(posedge phi0); #1;
    cpu_bus.cpu_req = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (ext_req) begin
        if (req_cycles == 0) begin
          sp = ext_space; ea = ext_addr; ernw = ext_rnw; ewd = ext_wdata;
        end
        req_cycles++;
      end
      if (cpu_bus.rdy) begin lat = n; dout = cpu_bus.data_In; break; end
      ext_ack = (ext_req && n == ack_at);
      @(posedge phi0); #1;
      ext_ack = 1'b0;
    end
    @(posedge phi0); #1;
    rdy_after = cpu_bus.rdy;
  endtask

  logic [7:0]  got, exp_d, ewd;
  logic        sp, ernw, rdy2;
  logic [15:0] ea;
  int          lat, exp_lat, reqc;
  bit          exp_valid;

  task automatic test_reset();
    if (cpu_bus.rdy !== 1'b0 || cpu_bus.data_In !== 8'h00) begin
      errors++; $display("FAIL reset_cpu rdy=%b data_In=%h need 0/00", cpu_bus.rdy, cpu_bus.data_In);
    end
    checks++;
    if ({ext_req, ext_space, ext_addr, ext_rnw, ext_wdata} !== {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_ext req=%b space=%b addr=%h rnw=%b wdata=%h need 0 0 0000 1 00",
                         ext_req, ext_space, ext_addr, ext_rnw, ext_wdata);
    end
    checks++;
    if (bus_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout got=%b need 0", bus_timeout);
    end
    checks++;
    // stray ack while idle must be ignored
    ext_ack = 1'b1;
    @(posedge phi0); #1;
    ext_ack = 1'b0;
    @(posedge phi0); #1;
    if (cpu_bus.rdy !== 1'b0 || ext_req !== 1'b0) begin
      errors++; $display("FAIL stray_ack rdy=%b ext_req=%b need 0/0", cpu_bus.rdy, ext_req);
    end
    checks++;
  endtask

  task automatic test_ram_mirror();
    logic [15:0] rd_addrs [3] = '{16'h0805, 16'h1005, 16'h1805};
    model_access(16'h0000, 0, 8'h3C, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h0000, 0, 8'h3C, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    model_access(16'h0005, 0, 8'hA5, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h0005, 0, 8'hA5, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    if (lat !== 1 || rdy2 !== 1'b0) begin
      errors++; $display("FAIL ram_write_timing lat=%0d rdy_after=%b need 1/0", lat, rdy2);
    end
    checks++;
    foreach (rd_addrs[i]) begin
      model_access(rd_addrs[i], 1, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
      access(rd_addrs[i], 1, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
      if (got !== 8'hA5 || lat !== 1 || rdy2 !== 1'b0 || reqc != 0) begin
        errors++; $display("FAIL ram_mirror addr=%h data=%h lat=%0d rdy_after=%b ext_cycles=%0d need A5 1 0 0",
                           rd_addrs[i], got, lat, rdy2, reqc);
      end
      checks++;
    end
  endtask

  task automatic test_controller();
    bit exp_bits [9] = '{1, 0, 0, 0, 1, 1, 0, 1, 1};
    pad1_buttons = 8'b1011_0001;
    pad2_buttons = 8'($urandom);
    model_access(16'h4016, 0, 8'h01, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h4016, 0, 8'h01, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    model_access(16'h4016, 0, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h4016, 0, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    for (int i = 0; i < 9; i++) begin
      model_access(16'h4016, 1, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
      access(16'h4016, 1, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
      if (got[0] !== exp_bits[i] || got[4:1] !== 4'b0000 || got !== exp_d || lat !== 1) begin
        errors++; $display("FAIL pad1_read_%0d data=%h lat=%0d need bit0=%0d data=%h lat=1",
                           i, got, lat, exp_bits[i], exp_d);
      end
      checks++;
    end
    model_access(16'h4017, 1, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h4017, 1, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    if (got !== exp_d) begin
      errors++; $display("FAIL pad2_first_read data=%h need %h", got, exp_d);
    end
    checks++;
    // strobe held high: each read returns the live A button
    model_access(16'h4016, 0, 8'h01, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h4016, 0, 8'h01, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    for (int i = 0; i < 4; i++) begin
      pad1_buttons = 8'($urandom) ^ 8'(i);
      model_access(16'h4016, 1, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
      access(16'h4016, 1, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
      if (got !== exp_d) begin
        errors++; $display("FAIL pad1_live_%0d data=%h need %h", i, got, exp_d);
      end
      checks++;
    end
    model_access(16'h4016, 0, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h4016, 0, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
  endtask

  task automatic test_cart_read();
    model_access(16'h8000, 1, 8'h00, 3, 8'h4C, exp_d, exp_lat, exp_valid);
    access(16'h8000, 1, 8'h00, 3, 8'h4C, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    if (reqc != 3 || sp !== 1'b1 || ea !== 16'h8000 || ernw !== 1'b1) begin
      errors++; $display("FAIL cart_req cycles=%0d space=%b addr=%h rnw=%b need 3 1 8000 1",
                         reqc, sp, ea, ernw);
    end
    checks++;
    if (got !== 8'h4C || lat !== exp_lat || rdy2 !== 1'b0) begin
      errors++; $display("FAIL cart_data data=%h lat=%0d rdy_after=%b need 4C %0d 0", got, lat, rdy2, exp_lat);
    end
    checks++;
  endtask

  task automatic test_ppu_write_open_bus();
    model_access(16'h2008, 0, 8'h80, 1, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h2008, 0, 8'h80, 1, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    if (sp !== 1'b0 || ea !== 16'h2000 || ernw !== 1'b0 || ewd !== 8'h80 || lat !== 2) begin
      errors++; $display("FAIL ppu_write space=%b addr=%h rnw=%b wdata=%h lat=%0d need 0 2000 0 80 2",
                         sp, ea, ernw, ewd, lat);
    end
    checks++;
    model_access(16'h4000, 1, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h4000, 1, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    if (got !== 8'h80 || got !== exp_d || lat !== 1) begin
      errors++; $display("FAIL open_bus_read data=%h lat=%0d need 80 1", got, lat);
    end
    checks++;
  endtask

  task automatic test_timeout();
    model_access(16'hC000, 1, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'hC000, 1, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    if (lat !== TIMEOUT + 1 || got !== exp_d) begin
      errors++; $display("FAIL timeout_resp lat=%0d data=%h need %0d %h", lat, got, TIMEOUT + 1, exp_d);
    end
    checks++;
    if (bus_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_flag got=%b need 1", bus_timeout);
    end
    checks++;
  endtask

  task automatic test_reset_in_wait();
    bit saw_rdy = 0;
    cpu_bus.cpu_req = 1'b1; cpu_bus.address = 16'h8000; cpu_bus.readNotWrite = 1'b1;
    @(posedge phi0); #1;
    cpu_bus.cpu_req = 1'b0;
    if (ext_req !== 1'b1) begin
      errors++; $display("FAIL rst_wait_req_rise got=%b need 1", ext_req);
    end
    checks++;
    @(posedge phi0); #1;
    res = 1'b1;
    @(posedge phi0); #1;
    if (ext_req !== 1'b0 || cpu_bus.rdy !== 1'b0) begin
      errors++; $display("FAIL rst_wait_drop ext_req=%b rdy=%b need 0/0", ext_req, cpu_bus.rdy);
    end
    checks++;
    res = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge phi0); #1;
      if (cpu_bus.rdy) saw_rdy = 1;
    end
    if (saw_rdy || bus_timeout !== 1'b0 || cpu_bus.data_In !== 8'h00) begin
      errors++; $display("FAIL rst_wait_quiet saw_rdy=%0d timeout=%b data_In=%h need 0 0 00",
                         saw_rdy, bus_timeout, cpu_bus.data_In);
    end
    checks++;
    model_access(16'h0000, 1, 8'h00, 0, 8'h00, exp_d, exp_lat, exp_valid);
    access(16'h0000, 1, 8'h00, 0, 8'h00, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
    if (got !== 8'h3C || lat !== 1) begin
      errors++; $display("FAIL rst_wait_ram data=%h lat=%0d need 3C 1", got, lat);
    end
    checks++;
  endtask

  task automatic test_random_mix();
    logic [15:0] a;
    bit rnw;
    logic [7:0] wd, rd;
    int ack_at;
    for (int it = 0; it < 80; it++) begin
      if (it % 10 == 0) begin
        pad1_buttons = 8'($urandom); pad2_buttons = 8'($urandom);
      end
      case ($urandom_range(0, 5))
        0, 5: a = 16'($urandom_range(0, 16'h1FFF));
        1:    a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:    a = 16'($urandom_range(16'h4020, 16'hFFFF));
        3:    a = ($urandom_range(0, 1) == 1) ? 16'h4017 : 16'h4016;
        default: a = 16'($urandom_range(16'h4000, 16'h401F));
      endcase
      rnw = bit'($urandom_range(0, 1));
      if (a < 16'h2000 && rnw && !m_valid[a % 2048]) rnw = 0;
      wd = 8'($urandom); rd = 8'($urandom);
      ack_at = $urandom_range(1, 3);
      model_access(a, rnw, wd, ack_at, rd, exp_d, exp_lat, exp_valid);
      access(a, rnw, wd, ack_at, rd, got, lat, reqc, sp, ea, ernw, ewd, rdy2);
      if (lat !== exp_lat || rdy2 !== 1'b0 || (exp_valid && got !== exp_d)) begin
        errors++; $display("FAIL rand_%0d addr=%h rnw=%0d data=%h lat=%0d rdy_after=%b need data=%h lat=%0d",
                           it, a, rnw, got, lat, rdy2, exp_d, exp_lat);
      end
      checks++;
      if (a >= 16'h2000 && (a < 16'h4000 || a >= 16'h4020)) begin
        if (sp !== (a >= 16'h4020) || ea !== ((a < 16'h4000) ? (16'h2000 | {13'd0, a[2:0]}) : a)
            || ernw !== rnw || (!rnw && ewd !== wd) || reqc != ack_at) begin
          errors++; $display("FAIL rand_ext_%0d addr=%h space=%b ext_addr=%h rnw=%b wdata=%h cycles=%0d",
                             it, a, sp, ea, ernw, ewd, reqc);
        end
        checks++;
      end else if (reqc != 0) begin
        errors++; $display("FAIL rand_noext_%0d addr=%h ext_req cycles=%0d need 0", it, a, reqc);
        checks++;
      end else begin
        checks++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_bus.cpu_req = 1'b0; cpu_bus.address = 16'h0000;
    cpu_bus.readNotWrite = 1'b1; cpu_bus.data_Out = 8'h00;
    model_reset();
    repeat (3) @(posedge phi0);
    #1 res = 1'b0;
    test_reset();
    test_ram_mirror();
    test_controller();
    test_cart_read();
    test_ppu_write_open_bus();
    test_timeout();
    test_reset_in_wait();
    test_random_mix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
